// File: rtl/nibble_view_wrapper.sv
// Debounced switch/button front end driving a loadable shift register with a nibble viewer.
// Latency: input-to-state is 2+DB_CYCLES+1 edges, state-to-output is combinational; no backpressure.

module nibble_view_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o
);
    // Counter only ever holds 0..DB_CYCLES-1; the toggle fires on the final differing sample.
    localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

module nibble_view_wrapper #(
    parameter int            W          = 8,
    parameter logic [W-1:0]  LOAD_VALUE = W'(8'hA5),
    parameter int            DB_CYCLES  = 4,
    localparam int           NIB        = W / 4,
    localparam int           NI         = (NIB > 1) ? $clog2(NIB) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    sw,
    input  logic [2:0]    btn,
    output logic [3:0]    led,
    output logic [NI-1:0] nib_idx,
    output logic          serialout
);
    if (W < 4 || (W % 4) != 0) begin : g_bad_w
        $error("nibble_view_wrapper: W must be a multiple of 4 and at least 4");
    end
    if (DB_CYCLES < 1) begin : g_bad_db
        $error("nibble_view_wrapper: DB_CYCLES must be at least 1");
    end

    // Bit order: {btn[2], btn[1], btn[0], sw[1], sw[0]}
    logic [4:0]    raw;
    logic [4:0]    lvl;
    logic [4:1]    lvl_prev_q;
    logic [4:1]    rise;

    logic [W-1:0]  sr_q;
    logic [W-1:0]  sr_d;
    logic [NI-1:0] idx_q;
    logic [NI-1:0] idx_d;

    logic          evt_shift;
    logic          evt_load;
    logic          evt_dn;
    logic          evt_up;

    assign raw = {btn, sw};

    for (genvar g = 0; g < 5; g++) begin : g_db
        nibble_view_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .raw_i   (raw[g]),
            .level_o (lvl[g])
        );
    end

    // Only rising edges of the debounced level are events, so a held press fires once.
    assign rise      = lvl[4:1] & ~lvl_prev_q;
    assign evt_shift = rise[1];
    assign evt_load  = rise[2];
    assign evt_dn    = rise[3];
    assign evt_up    = rise[4];

    always_comb begin
        sr_d = sr_q;
        if (evt_load) begin
            sr_d = LOAD_VALUE;
        end else if (evt_shift) begin
            sr_d = {sr_q[W-2:0], lvl[0]};
        end
    end

    // With a single nibble both wrap targets are 0, so the index stays put for W=4.
    always_comb begin
        idx_d = idx_q;
        if (evt_up && !evt_dn) begin
            idx_d = (idx_q == NI'(NIB - 1)) ? '0 : idx_q + 1'b1;
        end else if (evt_dn && !evt_up) begin
            idx_d = (idx_q == '0) ? NI'(NIB - 1) : idx_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_prev_q <= '0;
            sr_q       <= '0;
            idx_q      <= '0;
        end else begin
            lvl_prev_q <= lvl[4:1];
            sr_q       <= sr_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        led = '0;
        for (int n = 0; n < NIB; n++) begin
            if (idx_q == NI'(n)) begin
                led = sr_q[4*n +: 4];
            end
        end
    end

    assign nib_idx   = idx_q;
    assign serialout = sr_q[W-1];

endmodule
